// File: rtl/motor_ramp.sv
// Command shaper ahead of motor_controller: slew-limited duty, ramp-through-zero
// reversals with a dead time before the direction bit flips, and emergency stop.
module motor_ramp #(
   parameter int unsigned STEP       = 8,
   parameter int unsigned TICK_DIV   = 50000,
   parameter int unsigned DEAD_TICKS = 4
) (
   input  logic        CLOCK_50,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [10:0] cmd_speed,
   input  logic        estop,
   output logic        direction,
   output logic        enable,
   output logic [9:0]  duty,
   output logic        busy
);

   localparam int unsigned CW = $clog2(TICK_DIV);
   localparam int unsigned DW = $clog2(DEAD_TICKS + 1);
   localparam logic [9:0]    STEP10    = 10'(STEP);
   localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);
   localparam logic [DW-1:0] DEAD_LOAD = DW'(DEAD_TICKS);

   typedef enum logic [1:0] {IDLE, RAMP, DEAD} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q;
   logic [9:0]    duty_q, duty_d;
   logic          dir_q, dir_d;
   logic          en_q;
   logic          tdir_q, tdir_d;
   logic [9:0]    tmag_q, tmag_d;
   logic [DW-1:0] dead_q, dead_d;
   logic          tick;
   logic [10:0]   cmd_abs;
   logic [9:0]    cmd_mag;

   // Move cur one STEP toward tgt, landing exactly on tgt when within reach.
   function automatic logic [9:0] approach(input logic [9:0] cur, input logic [9:0] tgt);
      logic [10:0] up;
      up = {1'b0, cur} + {1'b0, STEP10};
      if (cur < tgt)
         return (up >= {1'b0, tgt}) ? tgt : up[9:0];
      else if (cur > tgt)
         return ((cur - tgt) <= STEP10) ? tgt : (cur - STEP10);
      else
         return cur;
   endfunction

   assign tick    = (cnt_q == TICK_LAST);
   assign cmd_abs = cmd_speed[10] ? (~cmd_speed + 11'd1) : cmd_speed;
   assign cmd_mag = cmd_abs[10] ? 10'd1023 : cmd_abs[9:0];

   assign cmd_ready = !estop && (state_q != DEAD);
   assign busy      = (state_q == DEAD) || (duty_q != tmag_q) ||
                      ((tmag_q != '0) && (dir_q != tdir_q));
   assign direction = dir_q;
   assign enable    = en_q;
   assign duty      = duty_q;

   always_comb begin
      state_d = state_q;
      duty_d  = duty_q;
      dir_d   = dir_q;
      tdir_d  = tdir_q;
      tmag_d  = tmag_q;
      dead_d  = dead_q;
      if (cmd_valid && cmd_ready) begin
         tdir_d = ~cmd_speed[10];
         tmag_d = cmd_mag;
      end
      if (estop) begin
         duty_d  = '0;
         tmag_d  = '0;
         tdir_d  = dir_q;
         state_d = IDLE;
         dead_d  = '0;
      end else if (tick) begin
         case (state_q)
            // IDLE shares the RAMP evaluation so a new command moves duty on the first tick.
            IDLE, RAMP: begin
               if ((tmag_q != '0) && (tdir_q != dir_q)) begin
                  if (duty_q == '0) begin
                     state_d = DEAD;
                     dead_d  = DEAD_LOAD;
                  end else begin
                     duty_d  = approach(duty_q, '0);
                     state_d = RAMP;
                  end
               end else begin
                  duty_d  = approach(duty_q, tmag_q);
                  state_d = ((duty_d == '0) && (tmag_q == '0)) ? IDLE : RAMP;
               end
            end
            DEAD: begin
               dead_d = dead_q - DW'(1);
               if (dead_q == DW'(1)) begin
                  dir_d   = tdir_q;
                  state_d = RAMP;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         cnt_q   <= '0;
         state_q <= IDLE;
         duty_q  <= '0;
         dir_q   <= 1'b1;
         en_q    <= 1'b0;
         tdir_q  <= 1'b1;
         tmag_q  <= '0;
         dead_q  <= '0;
      end else begin
         cnt_q   <= tick ? '0 : cnt_q + CW'(1);
         state_q <= state_d;
         duty_q  <= duty_d;
         dir_q   <= dir_d;
         en_q    <= (duty_d != '0);
         tdir_q  <= tdir_d;
         tmag_q  <= tmag_d;
         dead_q  <= dead_d;
      end
   end

endmodule

// File: tb/tb_motor_ramp.sv
// Directed bench for motor_ramp: per-tick vector tables plus hand sequences for
// estop, clamp and asynchronous reset.
module tb_motor_ramp;

   logic        clk;
   logic        reset;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [10:0] cmd_speed;
   logic        estop;
   logic        direction;
   logic        enable;
   logic [9:0]  duty;
   logic        busy;

   int total = 0;
   int bad   = 0;
   int edges = 0;
   int vidx  = 0;

   typedef struct {
      logic        valid;
      logic [10:0] speed;
      int          duty;
      int          dir;
      int          en;
      int          busy;
      int          ready;
   } vec_t;

   vec_t vq[$];

   motor_ramp #(.STEP(8), .TICK_DIV(4), .DEAD_TICKS(2)) dut (
      .CLOCK_50 (clk),
      .reset    (reset),
      .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready),
      .cmd_speed(cmd_speed),
      .estop    (estop),
      .direction(direction),
      .enable   (enable),
      .duty     (duty),
      .busy     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not complete, total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      edges++;
      #1;
   endtask

   // Tick edges fall on every 4th edge counted from reset release.
   task automatic to_tick();
      while (edges % 4 != 0) step();
   endtask

   task automatic next_tick();
      step();
      to_tick();
   endtask

   function void add_vec(input logic v, input logic [10:0] s, input int d, input int dr,
                         input int e, input int b, input int r);
      vec_t x;
      x.valid = v; x.speed = s; x.duty = d; x.dir = dr; x.en = e; x.busy = b; x.ready = r;
      vq.push_back(x);
   endfunction

   task automatic run_vectors();
      for (int i = 0; i < vq.size(); i++) begin
         cmd_valid = vq[i].valid;
         cmd_speed = vq[i].speed;
         step();
         cmd_valid = 1'b0;
         to_tick();
         chk($sformatf("vec%0d_duty", vidx), int'(duty), vq[i].duty);
         chk($sformatf("vec%0d_dir", vidx), int'(direction), vq[i].dir);
         chk($sformatf("vec%0d_en", vidx), int'(enable), vq[i].en);
         chk($sformatf("vec%0d_busy", vidx), int'(busy), vq[i].busy);
         chk($sformatf("vec%0d_ready", vidx), int'(cmd_ready), vq[i].ready);
         vidx++;
      end
      vq.delete();
   endtask

   initial begin
      int prev;
      int cur;
      int steps_ok;
      int dir_ok;

      reset     = 1'b1;
      cmd_valid = 1'b0;
      cmd_speed = '0;
      estop     = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      edges = 0;
      chk("rst_duty", int'(duty), 0);
      chk("rst_dir", int'(direction), 1);
      chk("rst_en", int'(enable), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_ready", int'(cmd_ready), 1);
      repeat (20) step();
      chk("hold_duty", int'(duty), 0);
      chk("hold_dir", int'(direction), 1);
      chk("hold_en", int'(enable), 0);
      chk("hold_busy", int'(busy), 0);
      chk("hold_ready", int'(cmd_ready), 1);

      // Ramp up to +100
      add_vec(1'b1, 11'd100, 8, 1, 1, 1, 1);
      for (int k = 2; k <= 12; k++) add_vec(1'b0, '0, 8 * k, 1, 1, 1, 1);
      add_vec(1'b0, '0, 100, 1, 1, 0, 1);
      // Reverse to -50
      add_vec(1'b1, 11'h7CE, 92, 1, 1, 1, 1);
      for (int k = 2; k <= 12; k++) add_vec(1'b0, '0, 100 - 8 * k, 1, 1, 1, 1);
      add_vec(1'b0, '0, 0, 1, 0, 1, 1);
      add_vec(1'b0, '0, 0, 1, 0, 1, 0);
      add_vec(1'b0, '0, 0, 1, 0, 1, 0);
      add_vec(1'b0, '0, 0, 0, 0, 1, 1);
      for (int k = 1; k <= 6; k++) add_vec(1'b0, '0, 8 * k, 0, 1, 1, 1);
      add_vec(1'b0, '0, 50, 0, 1, 0, 1);
      // +200 from -50: down, dead time, up to 64
      add_vec(1'b1, 11'd200, 42, 0, 1, 1, 1);
      for (int k = 2; k <= 6; k++) add_vec(1'b0, '0, 50 - 8 * k, 0, 1, 1, 1);
      add_vec(1'b0, '0, 0, 0, 0, 1, 1);
      add_vec(1'b0, '0, 0, 0, 0, 1, 0);
      add_vec(1'b0, '0, 0, 0, 0, 1, 0);
      add_vec(1'b0, '0, 0, 1, 0, 1, 1);
      for (int k = 1; k <= 8; k++) add_vec(1'b0, '0, 8 * k, 1, 1, 1, 1);
      run_vectors();

      // Emergency stop at duty 64, with a competing command while held
      estop = 1'b1;
      step();
      chk("estop_duty", int'(duty), 0);
      chk("estop_en", int'(enable), 0);
      chk("estop_ready", int'(cmd_ready), 0);
      chk("estop_busy", int'(busy), 0);
      chk("estop_dir", int'(direction), 1);
      cmd_valid = 1'b1;
      cmd_speed = 11'd300;
      repeat (8) step();
      chk("estop_hold_duty", int'(duty), 0);
      chk("estop_hold_ready", int'(cmd_ready), 0);
      estop     = 1'b0;
      cmd_valid = 1'b0;
      step();
      chk("release_ready", int'(cmd_ready), 1);
      chk("release_busy", int'(busy), 0);
      to_tick();
      repeat (8) step();
      chk("release_duty", int'(duty), 0);
      chk("release_en", int'(enable), 0);

      add_vec(1'b1, 11'd40, 8, 1, 1, 1, 1);
      for (int k = 2; k <= 4; k++) add_vec(1'b0, '0, 8 * k, 1, 1, 1, 1);
      add_vec(1'b0, '0, 40, 1, 1, 0, 1);
      run_vectors();

      // Clamp: -1024 from IDLE
      estop = 1'b1;
      step();
      estop = 1'b0;
      to_tick();
      chk("clamp_idle_duty", int'(duty), 0);
      cmd_valid = 1'b1;
      cmd_speed = 11'h400;
      step();
      cmd_valid = 1'b0;
      chk("clamp_busy", int'(busy), 1);
      chk("clamp_dir_pre", int'(direction), 1);
      prev = -1;
      cur = 0;
      steps_ok = 1;
      dir_ok = 1;
      for (int t = 0; t < 200; t++) begin
         next_tick();
         cur = int'(duty);
         if (cur == 1023) break;
         if (cur % 8 != 0) steps_ok = 0;
         if (cur != 0 && direction != 1'b0) dir_ok = 0;
         prev = cur;
      end
      chk("clamp_final", cur, 1023);
      chk("clamp_prev", prev, 1016);
      chk("clamp_steps", steps_ok, 1);
      chk("clamp_dir_ramp", dir_ok, 1);
      chk("clamp_dir", int'(direction), 0);
      next_tick();
      chk("clamp_hold_duty", int'(duty), 1023);
      chk("clamp_hold_busy", int'(busy), 0);
      chk("clamp_hold_en", int'(enable), 1);

      // Asynchronous reset from reverse full speed
      reset = 1'b1;
      #1;
      chk("areset1_duty", int'(duty), 0);
      chk("areset1_dir", int'(direction), 1);
      chk("areset1_en", int'(enable), 0);
      @(posedge clk);
      #1 reset = 1'b0;
      edges = 0;
      chk("areset1_ready", int'(cmd_ready), 1);
      chk("areset1_busy", int'(busy), 0);

      // Asynchronous reset mid-ramp at duty 48
      cmd_valid = 1'b1;
      cmd_speed = 11'd100;
      step();
      cmd_valid = 1'b0;
      for (int t = 0; t < 6; t++) next_tick();
      chk("mid_duty", int'(duty), 48);
      reset = 1'b1;
      #2;
      chk("areset2_duty", int'(duty), 0);
      chk("areset2_en", int'(enable), 0);
      chk("areset2_dir", int'(direction), 1);
      chk("areset2_busy", int'(busy), 0);
      @(posedge clk);
      #1 reset = 1'b0;
      edges = 0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
